// File: rtl/uart_sender_fifo.sv
// Buffered 8N1 UART transmitter. Bytes enter a circular FIFO through a
// valid/ready port and are serialized LSB first, back-to-back while data is queued.
//
// Handshake: READY is high when the FIFO has a free slot and reset is released.
// A byte is accepted on every rising edge where VALID && READY.
// DATA is only sampled on that edge.
module uart_sender_fifo #(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               DATA,
  input  logic                     VALID,
  output logic                     READY,
  output logic                     TX,
  output logic                     BUSY,
  output logic [FIFO_DEPTH_LOG2:0] COUNT
);

  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] DEPTH      = CW'(2 ** FIFO_DEPTH_LOG2);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [0:(2**AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Serializer registers and their next values
  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          tx_reg, tx_n;

  assign READY = RST_N && (count != DEPTH);
  assign push  = VALID && READY;
  assign TX    = tx_reg;
  assign BUSY  = (state != S_IDLE) || (count != '0);
  assign COUNT = count;

  // FIFO storage write; no reset needed since push is blocked during reset
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= DATA;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serializer state register; TX is registered from the next state
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      tx_reg    <= tx_n;
    end
  end

  // Serializer next-state logic; a STOP expiry with queued data goes straight to START
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          timer_n = TIMER_LOAD;
          state_n = S_START;
        end
      end
      S_START: begin
        if (timer == '0) begin
          timer_n   = TIMER_LOAD;
          bit_idx_n = 3'd0;
          state_n   = S_DATA;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_DATA: begin
        if (timer == '0) begin
          timer_n = TIMER_LOAD;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = shift_reg >> 1;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_STOP: begin
        if (timer == '0) begin
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            timer_n = TIMER_LOAD;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Line level that goes with the next state
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_sender_fifo.sv
// Bench for uart_sender_fifo: directed scenarios plus random streaming,
// checked each cycle against a queue-based model of the FIFO and the 8N1 line.
module tb_uart_sender_fifo;

  localparam int CPB   = 4;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  // clock / reset
  logic clk;
  logic rst_n;
  logic [7:0] data;
  logic valid;
  logic ready;
  logic tx;
  logic busy;
  logic [LOG2:0] count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_sender_fifo #(
    .CLK_PER_BIT(CPB),
    .FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .DATA(data),
    .VALID(valid),
    .READY(ready),
    .TX(tx),
    .BUSY(busy),
    .COUNT(count)
  );

  int n_checks = 0;
  int n_pass = 0;
  int frames_done = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // scoreboard: bytes accepted and not yet started on the line
  logic [7:0] exp_q[$];

  logic       p_rst_n = 1'b0;
  logic       p_push = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       start_due = 1'b0;
  logic       in_frame = 1'b0;
  int         fcyc = 0;
  int         slot;
  int         phase;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] dec_byte = 8'h00;
  logic       exp_tx;

  // monitor: advance the model over the edge just passed, then compare outputs
  always @(negedge clk) begin
    exp_tx = 1'b1;
    if (!p_rst_n) begin
      exp_q.delete();
      in_frame = 1'b0;
      start_due = 1'b0;
    end else begin
      if (p_push) exp_q.push_back(p_data);
      if (in_frame) begin
        fcyc++;
        if (fcyc == FRAME) in_frame = 1'b0;
      end
      if (start_due) begin
        if (exp_q.size() != 0) cur_byte = exp_q.pop_front();
        in_frame = 1'b1;
        fcyc = 0;
      end
      if (in_frame) begin
        slot = fcyc / CPB;
        if (slot == 0) exp_tx = 1'b0;
        else if (slot <= 8) exp_tx = cur_byte[slot-1];
        else exp_tx = 1'b1;
      end
    end

    check("tx", tx, exp_tx);
    check("count", 32'(count), exp_q.size());
    check("count_max", 32'(count <= DEPTH), 1);
    check("busy", busy, in_frame || (exp_q.size() != 0));
    check("ready", ready, rst_n && (exp_q.size() != DEPTH));

    if (in_frame) begin
      slot = fcyc / CPB;
      phase = fcyc % CPB;
      if (slot >= 1 && slot <= 8 && phase == CPB / 2) dec_byte[slot-1] = tx;
      if (fcyc == FRAME - 1) begin
        check("decoded_byte", dec_byte, cur_byte);
        frames_done++;
      end
    end

    start_due = (!in_frame || fcyc == FRAME - 1) && (exp_q.size() != 0);
    p_rst_n = rst_n;
    p_push = rst_n && valid && (exp_q.size() != DEPTH);
    p_data = data;
  end

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    valid = 1'b1;
    data = b;
    for (int w = 0; w < 2000; w++) begin
      if (ready) begin
        @(posedge clk); #1;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("push_accepted", done, 1'b1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(posedge clk); #1;
    end
    check("idle_timeout", 32'(n < 5000), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    rst_n = 1'b0;
    valid = 1'b0;
    data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_ready_low", ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", ready, 1'b1);
    @(posedge clk); #1;

    // single byte: BUSY high for 41 samples from the accept edge
    push_byte(8'h55);
    wait_idle(n);
    check("single_busy_len", n, 41);

    // back-to-back: three frames with no idle cycle between them
    push_byte(8'hA3);
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_idle(n);
    check("b2b_busy_len", n, 119);

    // simultaneous push and STOP-expiry pop at COUNT=3
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i));
    repeat (37) @(posedge clk);
    #1;
    check("simul_count_before", 32'(count), 3);
    valid = 1'b1;
    data = 8'h99;
    @(posedge clk); #1;
    valid = 1'b0;
    check("simul_count_after", 32'(count), 3);
    wait_idle(n);

    // fill: hold VALID from idle until READY drops
    acc = 0;
    valid = 1'b1;
    data = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if (!ready) break;
      @(posedge clk); #1;
      acc++;
      data = 8'(acc);
    end
    valid = 1'b0;
    check("fill_accepted", acc, 17);
    check("fill_count", 32'(count), 16);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("fill_ready_low_len", n, 25);
    wait_idle(n);

    // reset during DATA bit 3 with 5 bytes queued
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
    repeat (13) @(posedge clk);
    #1;
    check("midrst_count_before", 32'(count), 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_count", 32'(count), 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_byte(8'h3C);
    wait_idle(n);

    // pointer wrap: random bytes with random VALID gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      push_byte(8'($urandom_range(0, 255)));
    end
    wait_idle(n);

    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("frames_done", frames_done, 1 + 3 + 5 + 17 + 1 + 40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
